// File: rtl/subleq_loader.sv
// Boot loader for the SUBLEQ word memory: takes a little-endian length header and
// that many little-endian words from a byte stream, writes them from address 0, then releases the CPU.
module subleq_loader (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [7:0]  iData,
    input  logic        iValid,
    output logic        oReady,
    output logic [12:0] oAddress,
    output logic [31:0] oData,
    output logic        oWren,
    output logic        oCpuReset,
    output logic        oDone,
    output logic        oError
);

    typedef enum logic [2:0] {
        HEADER,
        LOAD,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] MEM_DEPTH = 32'd8192;

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_index;
    logic [31:0] shift_reg;
    logic [31:0] word_count;
    logic [13:0] words_written;
    logic [13:0] written_next;
    logic [12:0] last_address;
    logic [31:0] last_data;
    logic [31:0] header_value;
    logic        accept;
    logic        last_byte;

    assign accept       = iValid && oReady;
    assign last_byte    = (byte_index == 2'd3);
    assign header_value = {iData, word_count[23:0]};
    assign written_next = words_written + 14'd1;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= HEADER;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HEADER: begin
                if (accept && last_byte) begin
                    if (header_value > MEM_DEPTH) begin
                        next_state = ERROR;
                    end else if (header_value == 32'd0) begin
                        next_state = DONE;
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept && last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if ({18'd0, written_next} == word_count) begin
                    next_state = DONE;
                end else begin
                    next_state = LOAD;
                end
            end
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = HEADER;
        endcase
    end

    // The byte index wraps naturally after the 4th byte, so every header and word starts at byte 0.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            byte_index    <= 2'd0;
            shift_reg     <= 32'd0;
            word_count    <= 32'd0;
            words_written <= 14'd0;
            last_address  <= 13'd0;
            last_data     <= 32'd0;
        end else begin
            case (state)
                HEADER: begin
                    if (accept) begin
                        word_count[{byte_index, 3'b000} +: 8] <= iData;
                        byte_index <= byte_index + 2'd1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shift_reg[{byte_index, 3'b000} +: 8] <= iData;
                        byte_index <= byte_index + 2'd1;
                    end
                end
                WRITE: begin
                    words_written <= written_next;
                    last_address  <= words_written[12:0];
                    last_data     <= shift_reg;
                end
                default: begin
                end
            endcase
        end
    end

    // Outside WRITE the memory port shows the last word written, keeping waveforms readable.
    assign oReady    = (state == HEADER) || (state == LOAD);
    assign oWren     = (state == WRITE);
    assign oAddress  = oWren ? words_written[12:0] : last_address;
    assign oData     = oWren ? shift_reg : last_data;
    assign oCpuReset = (state != DONE);
    assign oDone     = (state == DONE);
    assign oError    = (state == ERROR);

endmodule

// File: tb/tb_subleq_loader.sv
// Directed bench for subleq_loader: a monitor mirrors memory writes into a local array,
// and every expectation is a hand-computed constant.
module tb_subleq_loader;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [7:0]  iData;
    logic        iValid;
    logic        oReady;
    logic [12:0] oAddress;
    logic [31:0] oData;
    logic        oWren;
    logic        oCpuReset;
    logic        oDone;
    logic        oError;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;

    logic [31:0] mem [0:8191];
    int writeCount;
    int addr0Writes;
    int readyDuringWrite;
    int lastWriteCycle;
    int doneCycle;
    bit doneSeen;

    subleq_loader dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iData     (iData),
        .iValid    (iValid),
        .oReady    (oReady),
        .oAddress  (oAddress),
        .oData     (oData),
        .oWren     (oWren),
        .oCpuReset (oCpuReset),
        .oDone     (oDone),
        .oError    (oError)
    );

    always #5 iClock = ~iClock;

    always @(posedge iClock) cycleCount <= cycleCount + 1;

    // Capture every write cycle into the shadow memory, sampled away from the active edge.
    always @(negedge iClock) begin
        if (oWren) begin
            mem[oAddress] = oData;
            writeCount++;
            lastWriteCycle = cycleCount;
            if (oAddress == 13'd0) addr0Writes++;
            if (oReady) readyDuringWrite++;
        end
        if (oDone && !doneSeen) begin
            doneSeen = 1'b1;
            doneCycle = cycleCount;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        for (int i = 0; i < 8192; i++) mem[i] = 32'hDEADBEEF;
        writeCount = 0;
        addr0Writes = 0;
        readyDuringWrite = 0;
        lastWriteCycle = -100;
        doneCycle = -1;
        doneSeen = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge iClock);
        iReset = 1'b1;
        iValid = 1'b0;
        repeat (2) @(negedge iClock);
        iReset = 1'b0;
    endtask

    // Offer one byte after an idle gap and hold it until the loader takes it; returns at the negedge after the transfer.
    task automatic applyStimulus(input logic [7:0] value, input int gap);
        int waitCycles;
        iValid = 1'b0;
        repeat (gap) @(negedge iClock);
        iData = value;
        iValid = 1'b1;
        waitCycles = 0;
        while (!oReady && waitCycles < 64) begin
            @(negedge iClock);
            waitCycles++;
        end
        if (!oReady) checkOutput("byte accept timeout", {31'b0, oReady}, 32'd1);
        @(negedge iClock);
        iValid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] word, input int maxGap);
        logic [31:0] w;
        w = word;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(w[8*k +: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
    endtask

    task automatic offerIgnoredBytes();
        iData = 8'hAA;
        iValid = 1'b1;
        repeat (4) @(negedge iClock);
        iValid = 1'b0;
    endtask

    initial begin
        int badWords;
        iReset = 1'b0;
        iValid = 1'b0;
        iData = 8'h00;
        clearMonitor();

        // Reset state
        applyReset();
        checkOutput("reset oReady", {31'b0, oReady}, 32'd1);
        checkOutput("reset oWren", {31'b0, oWren}, 32'd0);
        checkOutput("reset oAddress", {19'b0, oAddress}, 32'd0);
        checkOutput("reset oData", oData, 32'd0);
        checkOutput("reset oCpuReset", {31'b0, oCpuReset}, 32'd1);
        checkOutput("reset oDone", {31'b0, oDone}, 32'd0);
        checkOutput("reset oError", {31'b0, oError}, 32'd0);

        // Two words, iValid held high
        clearMonitor();
        sendWord(32'd2, 0);
        sendWord(32'h00000003, 0);
        checkOutput("basic first write addr", {19'b0, oAddress}, 32'd0);
        checkOutput("basic oReady in WRITE", {31'b0, oReady}, 32'd0);
        sendWord(32'hFFFFFFFF, 0);
        checkOutput("basic second write addr", {19'b0, oAddress}, 32'd1);
        checkOutput("basic cpu held during last write", {31'b0, oCpuReset}, 32'd1);
        repeat (3) @(negedge iClock);
        checkOutput("basic mem0", mem[0], 32'h00000003);
        checkOutput("basic mem1", mem[1], 32'hFFFFFFFF);
        checkOutput("basic write cycles", writeCount, 32'd2);
        checkOutput("basic ready during write", readyDuringWrite, 32'd0);
        checkOutput("basic done latency", doneCycle - lastWriteCycle, 32'd1);
        checkOutput("basic oDone", {31'b0, oDone}, 32'd1);
        checkOutput("basic oCpuReset", {31'b0, oCpuReset}, 32'd0);
        checkOutput("basic held oData", oData, 32'hFFFFFFFF);
        offerIgnoredBytes();
        checkOutput("done oReady", {31'b0, oReady}, 32'd0);
        checkOutput("done no extra writes", writeCount, 32'd2);

        // Zero-length program
        applyReset();
        clearMonitor();
        sendWord(32'd0, 0);
        checkOutput("empty oDone next cycle", {31'b0, oDone}, 32'd1);
        checkOutput("empty oCpuReset", {31'b0, oCpuReset}, 32'd0);
        repeat (3) @(negedge iClock);
        checkOutput("empty no writes", writeCount, 32'd0);

        // Oversize header 8193
        applyReset();
        clearMonitor();
        sendWord(32'h00002001, 0);
        checkOutput("error oError", {31'b0, oError}, 32'd1);
        checkOutput("error oReady", {31'b0, oReady}, 32'd0);
        checkOutput("error oCpuReset", {31'b0, oCpuReset}, 32'd1);
        offerIgnoredBytes();
        checkOutput("error sticky", {31'b0, oError}, 32'd1);
        checkOutput("error oDone", {31'b0, oDone}, 32'd0);
        checkOutput("error no writes", writeCount, 32'd0);
        applyReset();
        checkOutput("error cleared", {31'b0, oError}, 32'd0);
        checkOutput("error back to HEADER", {31'b0, oReady}, 32'd1);

        // Full memory: N = 8192, word i holds i
        clearMonitor();
        sendWord(32'd8192, 0);
        for (int i = 0; i < 8192; i++) sendWord(i, 0);
        repeat (3) @(negedge iClock);
        badWords = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== i) badWords++;
        checkOutput("full last word", mem[8191], 32'h00001FFF);
        checkOutput("full bad words", badWords, 32'd0);
        checkOutput("full write count", writeCount, 32'd8192);
        checkOutput("full addr0 writes", addr0Writes, 32'd1);
        checkOutput("full oDone", {31'b0, oDone}, 32'd1);
        checkOutput("full done latency", doneCycle - lastWriteCycle, 32'd1);

        // Random idle gaps, N = 3
        applyReset();
        clearMonitor();
        sendWord(32'd3, 5);
        sendWord(32'h12345678, 5);
        sendWord(32'hA5A55A5A, 5);
        sendWord(32'h00FF00FF, 5);
        repeat (3) @(negedge iClock);
        checkOutput("gaps mem0", mem[0], 32'h12345678);
        checkOutput("gaps mem1", mem[1], 32'hA5A55A5A);
        checkOutput("gaps mem2", mem[2], 32'h00FF00FF);
        checkOutput("gaps write count", writeCount, 32'd3);
        checkOutput("gaps oDone", {31'b0, oDone}, 32'd1);

        // Reset after two bytes of word 1; reset coincides with a third offered byte
        applyReset();
        clearMonitor();
        sendWord(32'd3, 0);
        sendWord(32'h11223344, 0);
        applyStimulus(8'h55, 0);
        applyStimulus(8'h66, 0);
        iData = 8'h77;
        iValid = 1'b1;
        iReset = 1'b1;
        repeat (2) @(negedge iClock);
        iReset = 1'b0;
        iValid = 1'b0;
        repeat (3) @(negedge iClock);
        checkOutput("abort write count", writeCount, 32'd1);
        checkOutput("abort mem0", mem[0], 32'h11223344);
        checkOutput("abort mem1 untouched", mem[1], 32'hDEADBEEF);
        checkOutput("abort oCpuReset", {31'b0, oCpuReset}, 32'd1);
        checkOutput("abort never released", {31'b0, doneSeen}, 32'd0);
        checkOutput("abort back to HEADER", {31'b0, oReady}, 32'd1);

        clearMonitor();
        sendWord(32'd3, 0);
        sendWord(32'hCAFEBABE, 0);
        sendWord(32'h0BADF00D, 0);
        sendWord(32'h80000001, 0);
        repeat (3) @(negedge iClock);
        checkOutput("reload mem0", mem[0], 32'hCAFEBABE);
        checkOutput("reload mem1", mem[1], 32'h0BADF00D);
        checkOutput("reload mem2", mem[2], 32'h80000001);
        checkOutput("reload write count", writeCount, 32'd3);
        checkOutput("reload addr0 writes", addr0Writes, 32'd1);
        checkOutput("reload oDone", {31'b0, oDone}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
